// File: rtl/axi_isolate_seq_pkg.sv
// Shared types and elaboration helpers for the axi_isolate sequencer.
package axi_isolate_seq_pkg;

    // Global sequencer state: one port transition in flight at a time.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        RSTHOLD = 2'd2,
        RELEASE = 2'd3
    } seq_state_e;

    // Larger of two elaboration-time values.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Port index width; a single-port build still gets a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_isolate_seq_if.sv
// Per-port request/status bundle between the power manager, the isolation
// shims and the sequencer.
interface axi_isolate_seq_if #(
    parameter int unsigned NumPorts = 4
);
    logic [NumPorts-1:0] req_isolate_i;
    logic [NumPorts-1:0] clr_err_i;
    logic [NumPorts-1:0] isolated_i;
    logic [NumPorts-1:0] isolate_o;
    logic [NumPorts-1:0] port_rst_o;
    logic [NumPorts-1:0] ack_o;
    logic [NumPorts-1:0] err_o;
    logic                busy_o;

    // Environment side: manager requests and shim status in, sequencer status out.
    modport master (
        output req_isolate_i, clr_err_i, isolated_i,
        input  isolate_o, port_rst_o, ack_o, err_o, busy_o
    );

    // Sequencer side.
    modport slave (
        input  req_isolate_i, clr_err_i, isolated_i,
        output isolate_o, port_rst_o, ack_o, err_o, busy_o
    );
endinterface

// File: rtl/axi_isolate_seq_rr.sv
// Combinational round-robin picker: first set bit of need at or after rr,
// wrapping modulo NumPorts.
module axi_isolate_seq_rr
    import axi_isolate_seq_pkg::*;
#(
    parameter int unsigned NumPorts = 4,
    parameter int unsigned IdxW     = idx_width(NumPorts)
) (
    input  logic [NumPorts-1:0] need,
    input  logic [IdxW-1:0]     rr,
    output logic [IdxW-1:0]     grant,
    output logic                valid
);
    localparam logic [IdxW:0] PortsW = (IdxW+1)'(NumPorts);

    logic [2*NumPorts-1:0] dbl;
    logic [NumPorts-1:0]   rot;
    logic [IdxW-1:0]       off;
    logic [IdxW:0]         sum;

    // Rotate so rr lands on bit 0, count zeros up to the first request, rotate back.
    always_comb begin
        dbl = {need, need};
        rot = dbl[rr +: NumPorts];
        off = '0;
        for (int i = NumPorts - 1; i >= 0; i--) begin
            if (rot[i]) off = IdxW'(i);
        end
        sum = {1'b0, rr} + {1'b0, off};
        if (sum >= PortsW) sum = sum - PortsW;
        grant = sum[IdxW-1:0];
        valid = |need;
    end

endmodule

// File: rtl/axi_isolate_seq.sv
// Sequencer for a bank of axi_isolate shims: drains, resets and releases one
// port at a time, bounded by a shared timeout with sticky per-port errors.
module axi_isolate_seq
    import axi_isolate_seq_pkg::*;
#(
    parameter int unsigned NumPorts      = 4,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned RstHoldCycles = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    axi_isolate_seq_if.slave  bus
);
    localparam int unsigned IdxW = idx_width(NumPorts);
    localparam int unsigned CntW = $clog2(max_u(TimeoutCycles, RstHoldCycles));

    localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] RstHoldLast = CntW'(RstHoldCycles - 1);
    localparam logic [IdxW-1:0] LastIdx     = IdxW'(NumPorts - 1);

    seq_state_e          state_q, state_d;
    logic [IdxW-1:0]     sel_q, sel_d;
    logic [IdxW-1:0]     rr_q, rr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [NumPorts-1:0] iso_q, err_q;
    logic [NumPorts-1:0] need;
    logic [NumPorts-1:0] iso_set, iso_clr, err_set;
    logic [IdxW-1:0]     grant;
    logic                grant_vld;
    logic [NumPorts-1:0] sel_oh, rel_mask, act_mask, hold_mask;

    // Counter never wraps; it stops at all-ones.
    function automatic logic [CntW-1:0] cnt_inc(input logic [CntW-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // An errored port does not retry isolation; release is always wanted.
    assign need = (bus.req_isolate_i & ~iso_q & ~err_q) | (~bus.req_isolate_i & iso_q);

    axi_isolate_seq_rr #(
        .NumPorts (NumPorts),
        .IdxW     (IdxW)
    ) u_rr (
        .need  (need),
        .rr    (rr_q),
        .grant (grant),
        .valid (grant_vld)
    );

    // Next-state logic: grant in IDLE, then drain/hold or release the selected port.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        iso_set = '0;
        iso_clr = '0;
        err_set = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    sel_d   = grant;
                    rr_d    = (grant == LastIdx) ? '0 : grant + 1'b1;
                    cnt_d   = '0;
                    state_d = iso_q[grant] ? RELEASE : DRAIN;
                end
            end
            DRAIN: begin
                // A response on the last allowed cycle still counts as success.
                if (bus.isolated_i[sel_q]) begin
                    cnt_d   = '0;
                    state_d = RSTHOLD;
                end else if (cnt_q == TimeoutLast) begin
                    err_set[sel_q] = 1'b1;
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_inc(cnt_q);
                end
            end
            RSTHOLD: begin
                if (cnt_q == RstHoldLast) begin
                    iso_set[sel_q] = 1'b1;
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_inc(cnt_q);
                end
            end
            RELEASE: begin
                // The port is handed back either way; a stuck shim only flags an error.
                if (!bus.isolated_i[sel_q]) begin
                    iso_clr[sel_q] = 1'b1;
                    state_d        = IDLE;
                end else if (cnt_q == TimeoutLast) begin
                    iso_clr[sel_q] = 1'b1;
                    err_set[sel_q] = 1'b1;
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_inc(cnt_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and per-port flags; a timeout set beats a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            iso_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            iso_q   <= (iso_q | iso_set) & ~iso_clr;
            err_q   <= (err_q & ~bus.clr_err_i) | err_set;
        end
    end

    // Per-port masks for the selected port in each active state.
    always_comb begin
        sel_oh        = '0;
        sel_oh[sel_q] = 1'b1;
        rel_mask      = (state_q == RELEASE) ? sel_oh : '0;
        act_mask      = (state_q == DRAIN || state_q == RSTHOLD) ? sel_oh : '0;
        hold_mask     = (state_q == RSTHOLD) ? sel_oh : '0;
    end

    assign bus.isolate_o  = (iso_q & ~rel_mask) | act_mask;
    assign bus.port_rst_o = (iso_q & ~rel_mask) | hold_mask;
    assign bus.ack_o      = iso_q;
    assign bus.err_o      = err_q;
    assign bus.busy_o     = (state_q != IDLE);

endmodule

// File: doc/axi_isolate_seq.md
# axi_isolate_seq

Sequencer that drives the `isolate_i` inputs of up to `NumPorts` `axi_isolate` instances and holds each isolated downstream slave in reset. It sits between a power/reset manager (level requests per port) and the isolation shims in the interconnect. It services one port transition at a time (isolate or release), picking among pending ports round-robin. One shared timeout counter bounds each drain and release; a timed-out port gets a sticky error flag.

## Interface
- `NumPorts`, 4: number of managed `axi_isolate` instances (1..32).
- `TimeoutCycles`, 1024: maximum cycles to wait for `isolated_i` to change (≥2).
- `RstHoldCycles`, 4: cycles `port_rst_o` is held after drain before `ack_o` rises (≥1).
- `clk_i`  in  1  rising-edge clock.
- `rst_i`  in  1  reset; synchronous and active-high.
- `req_isolate_i`  in  NumPorts  level request per port: 1 = isolated, 0 = connected.
- `clr_err_i`  in  NumPorts  pulse clears the corresponding `err_o` bit.
- `isolate_o`  out  NumPorts  drives `axi_isolate.isolate_i`.
- `isolated_i`  in  NumPorts  from `axi_isolate.isolated_o`.
- `port_rst_o`  out  NumPorts  active-high reset to the downstream slave.
- `ack_o`  out  NumPorts  port is isolated and held in reset (equals `iso_q`).
- `err_o`  out  NumPorts  sticky timeout flag.
- `busy_o`  out  1  FSM is not in IDLE.

## Operation
- Per-port state: `iso_q`, `err_q`.
- Need vector: `need[i] = (req[i] & ~iso_q[i] & ~err_q[i]) | (~req[i] & iso_q[i])`.
- While `err_q[i]` is set, port i does not retry an isolate. Release is always serviced.
- Global FSM states: IDLE, DRAIN, RSTHOLD, RELEASE. Registers: `sel_q` (granted port), `rr_q` (round-robin pointer), `cnt_q`.
- **IDLE**
  - If `need` ≠ 0: grant the first set bit at or after `rr_q`, wrapping modulo NumPorts.
  - Set `sel_q` = grant and `rr_q` = grant+1 (wraps to 0).
  - Go to DRAIN if `~iso_q[grant]`, else RELEASE. Clear `cnt_q`.
- **DRAIN**
  - `isolate_o[sel]` = 1.
  - If `isolated_i[sel]`: go to RSTHOLD and clear `cnt_q`.
  - Else if `cnt_q == TimeoutCycles-1`: set `err_q[sel]`, go to IDLE. `isolate_o[sel]` falls, which aborts the attempt.
  - Else increment `cnt_q`.
  - `isolated_i` wins over timeout when both occur in the same cycle.
- **RSTHOLD**
  - `isolate_o[sel]` = 1 and `port_rst_o[sel]` = 1.
  - When `cnt_q == RstHoldCycles-1`: set `iso_q[sel]`, go to IDLE.
- **RELEASE**
  - `port_rst_o[sel]` = 0 and `isolate_o[sel]` = 0.
  - If `~isolated_i[sel]`: clear `iso_q[sel]`, go to IDLE.
  - Else on timeout: set `err_q[sel]`, clear `iso_q[sel]`, go to IDLE.
- Outputs (combinational from registers):
  - `isolate_o[i] = iso_q[i] & ~(RELEASE & sel==i) | ((DRAIN|RSTHOLD) & sel==i)`.
  - `port_rst_o[i] = iso_q[i] & ~(RELEASE & sel==i) | (RSTHOLD & sel==i)`.
- Request changes on the granted port during DRAIN, RSTHOLD or RELEASE are ignored until the FSM returns to IDLE, then re-evaluated through `need`.
- `clr_err_i[i]` clears `err_q[i]` in any state. If a timeout sets the same bit in the same cycle, the set wins.
- A change on `isolated_i[j]` for a non-granted port is ignored.

## Timing
- Reset, synchronous: state IDLE, `iso_q`/`err_q`/`rr_q`/`sel_q`/`cnt_q` = 0. All outputs = 0 in the cycle after reset is sampled.
- Grant latency: `need` high in IDLE at cycle t → `isolate_o` rises at t+1.
- Drain with `isolated_i` seen at cycle d: RSTHOLD from d+1. `ack_o` rises at d+1+RstHoldCycles.
- Timeout: with no response, exactly TimeoutCycles cycles spent in DRAIN or RELEASE. `err_o` rises on the following edge.
- Release: `isolate_o`/`port_rst_o` fall at t+1. `ack_o` falls the cycle after `isolated_i` is seen low.
- Back-to-back: at least one IDLE cycle between consecutive transitions.
- Fairness: with all ports requesting, grants rotate 0,1,…,NumPorts-1.
- `cnt_q` width: `$clog2(max(TimeoutCycles,RstHoldCycles))`. It saturates and never wraps.

## Structure
- Shared package `axi_isolate_seq_pkg`: state enum `seq_state_e` {IDLE, DRAIN, RSTHOLD, RELEASE}.
- Sub-module `axi_isolate_seq_rr`: combinational round-robin priority picker.
  - Inputs: `need`, `rr_q`.
  - Outputs: grant index and valid.
  - Implementation: rotate, leading-zero count, un-rotate.
- Top level holds the FSM, the counter and the per-port flags.

## Test plan
- Single isolate: NumPorts=4, `req_isolate_i`=0001, slave model raises `isolated_i[0]` 3 cycles after `isolate_o[0]` → `port_rst_o[0]` high for 4 cycles, then `ack_o`=0001 and `busy_o`=0.
- Round-robin: `req_isolate_i`=1111 raised together, fast slaves → `isolate_o` bits rise in order 0,1,2,3 with at least one IDLE cycle between grants. Second round starts at `rr_q`=0.
- Drain timeout: TimeoutCycles=16, `isolated_i[2]` stuck 0 → `isolate_o[2]` falls after exactly 16 DRAIN cycles and `err_o[2]`=1. No retry while `req_isolate_i[2]` stays 1. `clr_err_i[2]` pulse → retry starts the next IDLE cycle.
- Release: port 1 isolated, `req_isolate_i[1]` dropped → `port_rst_o[1]` and `isolate_o[1]` fall one cycle later. `ack_o[1]` falls the cycle after `isolated_i[1]`=0.
- Mid-operation reset: `rst_i` asserted during RSTHOLD → the next cycle shows all outputs 0 and state IDLE. After reset deasserts, a still-held request is re-granted.
- Simultaneous events: `isolated_i` rises on the timeout cycle → no error and RSTHOLD is entered. `clr_err_i` coinciding with a timeout → `err_o` stays 1.
